// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM state type, bank map constants and address decode for the LSU arbiter
package lsu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP,
      ERR
   } state_t;

   localparam logic [3:0] DMEM_LO = 4'h4;
   localparam logic [3:0] DMEM_HI = 4'h7;
   localparam logic [3:0] OP_BANK = 4'hE;
   localparam logic [3:0] IP_BANK = 4'hF;

   // bank_sel is addr[14:11]; only data memory and the two peripheral banks are mapped
   function automatic logic mapped(input logic [3:0] bank_sel);
      return (bank_sel >= DMEM_LO && bank_sel <= DMEM_HI) || bank_sel == OP_BANK || bank_sel == IP_BANK;
   endfunction

endpackage

// File: rtl/lsu_rr_arb2.sv
// lsu_rr_arb2: two-way round-robin pick with a last-granted pointer
module lsu_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       take,
   output logic       pick,
   output logic       any
);

   logic last;

   // on a tie the requester not granted last wins, otherwise the sole requester
   always_comb begin
      any  = |req;
      pick = &req ? ~last : req[1];
   end

   // pointer starts at 1 so requester 0 wins the first tie
   always_ff @(posedge clk) begin
      if (rst) last <= 1'b1;
      else if (take) last <= pick;
   end

endmodule

// File: rtl/lsu_arb.sv
// lsu_arb: arbitrates two requesters onto a single LSU port with address-map checking
module lsu_arb
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LD_LATENCY = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_m0_req,
   input  logic                  i_m0_we,
   input  logic [ADDR_WIDTH-1:0] i_m0_addr,
   input  logic [2:0]            i_m0_func,
   input  logic [DATA_WIDTH-1:0] i_m0_wdata,
   output logic                  o_m0_gnt,
   output logic                  o_m0_rvalid,
   output logic [DATA_WIDTH-1:0] o_m0_rdata,
   output logic                  o_m0_err,
   input  logic                  i_m1_req,
   input  logic                  i_m1_we,
   input  logic [ADDR_WIDTH-1:0] i_m1_addr,
   input  logic [2:0]            i_m1_func,
   input  logic [DATA_WIDTH-1:0] i_m1_wdata,
   output logic                  o_m1_gnt,
   output logic                  o_m1_rvalid,
   output logic [DATA_WIDTH-1:0] o_m1_rdata,
   output logic                  o_m1_err,
   output logic [ADDR_WIDTH-1:0] o_lsu_addr,
   output logic [2:0]            o_lsu_func,
   output logic                  o_lsu_wren,
   output logic [DATA_WIDTH-1:0] o_lsu_st_data,
   input  logic [DATA_WIDTH-1:0] i_lsu_ld_data
);

   localparam logic [2:0] WAIT_INIT = 3'(LD_LATENCY > 1 ? LD_LATENCY - 2 : 0);

   state_t                state, next;
   logic                  own, pick, any, take, we, drive, cap;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] addr, sel_addr;
   logic [2:0]            func, sel_func, cnt;
   logic [DATA_WIDTH-1:0] wdata, sel_wdata;

   lsu_rr_arb2 u_rr (
      .clk (i_clk),
      .rst (i_rst),
      .req ({i_m1_req, i_m0_req}),
      .take(take),
      .pick(pick),
      .any (any)
   );

   // winner's payload, latched only when leaving IDLE
   always_comb begin
      sel_we    = pick ? i_m1_we    : i_m0_we;
      sel_addr  = pick ? i_m1_addr  : i_m0_addr;
      sel_func  = pick ? i_m1_func  : i_m0_func;
      sel_wdata = pick ? i_m1_wdata : i_m0_wdata;
      take      = state == IDLE && any;
      cap       = state == WAIT ? cnt == 3'd0 : state == ISSUE && !we && LD_LATENCY == 1;
   end

   // next-state: unmapped banks bypass the LSU entirely
   always_comb begin
      next = state;
      case (state)
         IDLE:    if (any) next = mapped(sel_addr[14:11]) ? ISSUE : ERR;
         ISSUE:   next = we ? IDLE : (LD_LATENCY == 1 ? RESP : WAIT);
         WAIT:    if (cnt == 3'd0) next = RESP;
         default: next = IDLE;
      endcase
   end

   // state, owner, payload and wait countdown
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         own   <= 1'b0;
         we    <= 1'b0;
         addr  <= '0;
         func  <= '0;
         wdata <= '0;
         cnt   <= '0;
      end else begin
         state <= next;
         if (take) begin
            own   <= pick;
            we    <= sel_we;
            addr  <= sel_addr;
            func  <= sel_func;
            wdata <= sel_wdata;
         end
         if (state == ISSUE) cnt <= WAIT_INIT;
         else if (state == WAIT) cnt <= cnt - 3'd1;
      end
   end

   // load data lands in the owner's register and holds until its next load
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_m0_rdata <= '0;
         o_m1_rdata <= '0;
      end else if (cap) begin
         if (own) o_m1_rdata <= i_lsu_ld_data;
         else o_m0_rdata <= i_lsu_ld_data;
      end
   end

   // LSU is driven only while the access is in flight; handshakes decode from state
   always_comb begin
      drive         = state == ISSUE || state == WAIT;
      o_lsu_addr    = drive ? addr  : '0;
      o_lsu_func    = drive ? func  : '0;
      o_lsu_st_data = drive ? wdata : '0;
      o_lsu_wren    = state == ISSUE && we;
      o_m0_gnt      = (state == ISSUE || state == ERR) && !own;
      o_m1_gnt      = (state == ISSUE || state == ERR) && own;
      o_m0_err      = state == ERR && !own;
      o_m1_err      = state == ERR && own;
      o_m0_rvalid   = state == RESP && !own;
      o_m1_rvalid   = state == RESP && own;
   end

endmodule

// File: tb/tb_lsu_arb.sv
// tb_lsu_arb: directed and random checks of lsu_arb at load latencies 1 and 3 against a transaction model
module tb_lsu_arb;

   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   logic          req   [2][2];
   logic          we    [2][2];
   logic [AW-1:0] addr  [2][2];
   logic [2:0]    func  [2][2];
   logic [DW-1:0] wdata [2][2];
   logic          gnt   [2][2];
   logic          rvalid[2][2];
   logic          err   [2][2];
   logic [DW-1:0] rdata [2][2];
   logic [AW-1:0] lsu_addr[2];
   logic [2:0]    lsu_func[2];
   logic          lsu_wren[2];
   logic [DW-1:0] lsu_st  [2];
   logic [DW-1:0] ld_data [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      lsu_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LD_LATENCY(g == 0 ? 1 : 3)) u_dut (
         .i_clk        (clk),
         .i_rst        (rst),
         .i_m0_req     (req[g][0]),
         .i_m0_we      (we[g][0]),
         .i_m0_addr    (addr[g][0]),
         .i_m0_func    (func[g][0]),
         .i_m0_wdata   (wdata[g][0]),
         .o_m0_gnt     (gnt[g][0]),
         .o_m0_rvalid  (rvalid[g][0]),
         .o_m0_rdata   (rdata[g][0]),
         .o_m0_err     (err[g][0]),
         .i_m1_req     (req[g][1]),
         .i_m1_we      (we[g][1]),
         .i_m1_addr    (addr[g][1]),
         .i_m1_func    (func[g][1]),
         .i_m1_wdata   (wdata[g][1]),
         .o_m1_gnt     (gnt[g][1]),
         .o_m1_rvalid  (rvalid[g][1]),
         .o_m1_rdata   (rdata[g][1]),
         .o_m1_err     (err[g][1]),
         .o_lsu_addr   (lsu_addr[g]),
         .o_lsu_func   (lsu_func[g]),
         .o_lsu_wren   (lsu_wren[g]),
         .o_lsu_st_data(lsu_st[g]),
         .i_lsu_ld_data(ld_data[g])
      );
   end

   int vectors = 0;
   int miscompares = 0;

   // transaction model: k counts cycles since the arbitration cycle of the current access
   bit            act;
   int            k, occ;
   bit            own, m_we, m_map, last;
   logic [AW-1:0] m_addr;
   logic [2:0]    m_func;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata[2];
   bit            got[2], keep[2];
   int            gq[$];

   function automatic int lat_of(input int d);
      return d == 0 ? 1 : 3;
   endfunction

   function automatic bit mapped_ref(input logic [AW-1:0] a);
      int b;
      b = int'(a[14:11]);
      return b inside {4, 5, 6, 7, 14, 15};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check(input int d);
      logic [AW-1:0] ea = '0;
      logic [2:0]    ef = '0;
      logic          ew = 1'b0;
      logic [DW-1:0] es = '0;
      logic          eg[2] = '{1'b0, 1'b0};
      logic          ev[2] = '{1'b0, 1'b0};
      logic          ee[2] = '{1'b0, 1'b0};
      bit            win = 1'b0;
      if (act) begin
         win = m_map && (k == 1 || (!m_we && k <= lat_of(d)));
         if (k == 1) begin
            eg[own] = 1'b1;
            ee[own] = !m_map;
            ew = m_map && m_we;
            if (m_map) es = m_wdata;
         end
         if (win) begin
            ea = m_addr;
            ef = m_func;
         end
         if (m_map && !m_we && k == lat_of(d) + 1) ev[own] = 1'b1;
      end
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("d%0d m%0d gnt", d, m), 64'(gnt[d][m]), 64'(eg[m]));
         chk($sformatf("d%0d m%0d rvalid", d, m), 64'(rvalid[d][m]), 64'(ev[m]));
         chk($sformatf("d%0d m%0d err", d, m), 64'(err[d][m]), 64'(ee[m]));
         chk($sformatf("d%0d m%0d rdata", d, m), 64'(rdata[d][m]), 64'(m_rdata[m]));
         if (gnt[d][m] === 1'b1) begin
            got[m] = 1'b1;
            gq.push_back(m);
         end
      end
      chk($sformatf("d%0d lsu_addr", d), 64'(lsu_addr[d]), 64'(ea));
      chk($sformatf("d%0d lsu_func", d), 64'(lsu_func[d]), 64'(ef));
      chk($sformatf("d%0d lsu_wren", d), 64'(lsu_wren[d]), 64'(ew));
      if (!(win && k > 1)) chk($sformatf("d%0d lsu_st_data", d), 64'(lsu_st[d]), 64'(es));
   endtask

   task automatic advance(input int d);
      if (rst) begin
         act = 1'b0;
         last = 1'b1;
         m_rdata = '{'0, '0};
      end else if (act) begin
         if (m_map && !m_we && k == lat_of(d)) m_rdata[own] = ld_data[d];
         if (k == occ - 1) act = 1'b0;
         else k++;
      end else if (req[d][0] || req[d][1]) begin
         own = (req[d][0] && req[d][1]) ? !last : req[d][1];
         last = own;
         m_we = we[d][own];
         m_addr = addr[d][own];
         m_func = func[d][own];
         m_wdata = wdata[d][own];
         m_map = mapped_ref(m_addr);
         occ = (!m_map || m_we) ? 2 : 2 + lat_of(d);
         k = 1;
         act = 1'b1;
      end
   endtask

   task automatic cycle(input int d);
      @(negedge clk);
      check(d);
      advance(d);
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) if (got[m]) begin
         got[m] = 1'b0;
         if (!keep[m]) req[d][m] = 1'b0;
      end
   endtask

   task automatic put(input int d, input int m, input logic w, input logic [AW-1:0] a,
                      input logic [2:0] f, input logic [DW-1:0] wd);
      req[d][m] = 1'b1;
      we[d][m] = w;
      addr[d][m] = a;
      func[d][m] = f;
      wdata[d][m] = wd;
   endtask

   task automatic drain(input int d);
      for (int i = 0; i < 60 && (req[d][0] || req[d][1]); i++) cycle(d);
      chk($sformatf("d%0d drain", d), 64'({req[d][0], req[d][1]}), 64'(0));
      repeat (6) cycle(d);
   endtask

   task automatic rand_run(input int d, input int n);
      logic [AW-1:0] a;
      for (int i = 0; i < n; i++) begin
         for (int m = 0; m < 2; m++) if (!req[d][m] && $urandom_range(0, 2) == 0) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[14:11] = 4'($urandom_range(4, 7));
            put(d, m, 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom);
         end
         ld_data[d] = $urandom;
         cycle(d);
      end
      drain(d);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         ld_data[d] = '0;
         for (int m = 0; m < 2; m++) begin
            req[d][m] = 1'b0;
            we[d][m] = 1'b0;
            addr[d][m] = '0;
            func[d][m] = '0;
            wdata[d][m] = '0;
         end
      end
      got = '{1'b0, 1'b0};
      keep = '{1'b0, 1'b0};
      repeat (2) @(posedge clk);
      #1;
      act = 1'b0;
      last = 1'b1;
      m_rdata = '{'0, '0};
      cycle(0);
      rst = 1'b0;
      cycle(0);

      put(0, 0, 1'b1, 32'h2004, 3'b010, 32'hDEADBEEF);
      cycle(0);
      chk("store gnt", 64'(gnt[0][0]), 64'(1));
      chk("store wren", 64'(lsu_wren[0]), 64'(1));
      chk("store addr", 64'(lsu_addr[0]), 64'h2004);
      chk("store data", 64'(lsu_st[0]), 64'hDEADBEEF);
      cycle(0);
      chk("store once wren", 64'(lsu_wren[0]), 64'(0));
      chk("store once gnt", 64'(gnt[0][0]), 64'(0));
      repeat (2) cycle(0);

      ld_data[0] = 32'h0000000A;
      put(0, 1, 1'b0, 32'h7800, 3'b010, 32'h0);
      cycle(0);
      chk("load gnt", 64'(gnt[0][1]), 64'(1));
      cycle(0);
      chk("load rvalid", 64'(rvalid[0][1]), 64'(1));
      chk("load rdata", 64'(rdata[0][1]), 64'hA);
      cycle(0);
      chk("load rvalid pulse", 64'(rvalid[0][1]), 64'(0));

      gq.delete();
      keep = '{1'b1, 1'b1};
      put(0, 0, 1'b0, 32'h2000, 3'b000, 32'h0);
      put(0, 1, 1'b0, 32'h7000, 3'b001, 32'h0);
      repeat (13) cycle(0);
      keep = '{1'b0, 1'b0};
      drain(0);
      chk("rr grants", 64'(gq.size() >= 4), 64'(1));
      foreach (gq[i]) chk($sformatf("rr order %0d", i), 64'(gq[i]), 64'(i % 2));

      put(0, 0, 1'b0, 32'h4000, 3'b010, 32'h0);
      cycle(0);
      chk("err flag", 64'(err[0][0]), 64'(1));
      chk("err gnt", 64'(gnt[0][0]), 64'(1));
      chk("err wren", 64'(lsu_wren[0]), 64'(0));
      cycle(0);
      chk("err rvalid", 64'(rvalid[0][0]), 64'(0));
      cycle(0);

      rand_run(0, 600);
      rst = 1'b1;
      cycle(0);
      rst = 1'b0;

      ld_data[1] = 32'h12345678;
      put(1, 0, 1'b0, 32'h3000, 3'b100, 32'h0);
      cycle(1);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("lat3 addr %0d", i), 64'(lsu_addr[1]), 64'h3000);
         cycle(1);
      end
      chk("lat3 rvalid", 64'(rvalid[1][0]), 64'(1));
      chk("lat3 rdata", 64'(rdata[1][0]), 64'h12345678);
      cycle(1);
      put(1, 0, 1'b0, 32'h3000, 3'b100, 32'h0);
      repeat (2) cycle(1);
      rst = 1'b1;
      cycle(1);
      chk("rst rvalid", 64'(rvalid[1][0]), 64'(0));
      chk("rst gnt", 64'(gnt[1][0]), 64'(0));
      chk("rst addr", 64'(lsu_addr[1]), 64'(0));
      chk("rst wren", 64'(lsu_wren[1]), 64'(0));
      chk("rst rdata", 64'(rdata[1][0]), 64'(0));
      rst = 1'b0;
      repeat (4) cycle(1);

      rand_run(1, 600);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
